// File: rtl/fp_mul_seq_if.sv
// rtl/fp_mul_seq_if.sv - operand/result handshake bundle for fp_mul_seq
interface fp_mul_seq_if #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
);
   localparam int W = 1 + EXP_W + MAN_W;

   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] result;
   logic [2:0]   status;

   modport master (
      output in_valid, a, b, out_ready,
      input  in_ready, out_valid, result, status
   );

   modport slave (
      input  in_valid, a, b, out_ready,
      output in_ready, out_valid, result, status
   );
endinterface

// File: rtl/fp_mul_seq.sv
// rtl/fp_mul_seq.sv - sequential shift-add float multiplier; FP_MUL_ROUND_EN enables round-to-nearest-even
module fp_mul_seq #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic        clk,
   input  logic        rst_n,
   fp_mul_seq_if.slave bus
);
   localparam int W  = 1 + EXP_W + MAN_W;
   localparam int PW = 2 * MAN_W + 2;
   localparam int EW = EXP_W + 2;
   localparam int CW = $clog2(MAN_W + 2);

   localparam logic signed [EW-1:0] BIAS    = EW'((1 << (EXP_W - 1)) - 1);
   localparam logic signed [EW-1:0] EXP_MAX = EW'((1 << EXP_W) - 1);
   localparam logic signed [EW-1:0] E_ONE   = EW'(1);

   localparam logic [2:0] ST_VALID     = 3'd0;
   localparam logic [2:0] ST_OVERFLOW  = 3'd1;
   localparam logic [2:0] ST_UNDERFLOW = 3'd2;
   localparam logic [2:0] ST_NAN       = 3'd3;
   localparam logic [2:0] ST_POS_INF   = 3'd4;
   localparam logic [2:0] ST_NEG_INF   = 3'd5;
   localparam logic [2:0] ST_ZERO      = 3'd6;

   typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} state_t;

   state_t        state_q, state_d;
   logic [W-1:0]  a_q, b_q;
   logic [PW-1:0] prod_q;
   logic [CW-1:0] cnt_q;

   // zero (including flushed denormals) and inf/NaN share the special path
   function automatic logic is_special(input logic [W-1:0] x);
      return (x[W-2:MAN_W] == '0) || (&x[W-2:MAN_W]);
   endfunction

   logic [EXP_W-1:0] ea, eb;
   logic [MAN_W-1:0] ma, mb;
   logic             sign_r;
   logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

   assign ea     = a_q[W-2:MAN_W];
   assign eb     = b_q[W-2:MAN_W];
   assign ma     = a_q[MAN_W-1:0];
   assign mb     = b_q[MAN_W-1:0];
   assign sign_r = a_q[W-1] ^ b_q[W-1];
   assign a_zero = (ea == '0);
   assign b_zero = (eb == '0);
   assign a_inf  = (&ea) && (ma == '0);
   assign b_inf  = (&eb) && (mb == '0);
   assign a_nan  = (&ea) && (ma != '0);
   assign b_nan  = (&eb) && (mb != '0);

   assign bus.in_ready = (state_q == IDLE);

   // state register
   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // next-state decode
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (bus.in_valid)
                  state_d = (is_special(bus.a) || is_special(bus.b)) ? DONE : MUL;
         MUL:  if (cnt_q == CW'(MAN_W)) state_d = NORM;
         NORM: state_d = DONE;
         DONE: if (bus.out_valid && bus.out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // one shift-add step: add multiplicand into the upper half when the multiplier LSB is set
   logic [MAN_W+1:0] step_sum;
   assign step_sum = {1'b0, prod_q[PW-1:MAN_W+1]} + (prod_q[0] ? {2'b01, ma} : '0);

   // special-operand result; NaN outranks inf, and inf x zero is NaN
   logic [W-1:0] spec_result;
   logic [2:0]   spec_status;
   always_comb begin
      spec_result = {sign_r, {(W-1){1'b0}}};
      spec_status = ST_ZERO;
      if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf)) begin
         spec_result = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
         spec_status = ST_NAN;
      end else if (a_inf || b_inf) begin
         spec_result = {sign_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         spec_status = sign_r ? ST_NEG_INF : ST_POS_INF;
      end
   end

   // normalise the finished product, optionally round, then range-check the exponent
   logic signed [EW-1:0] exp_raw, exp_n, exp_f;
   logic [MAN_W-1:0]     mant_t, mant_f;
   logic [W-1:0]         norm_result;
   logic [2:0]           norm_status;
`ifdef FP_MUL_ROUND_EN
   logic             guard, sticky, round_up;
   logic [MAN_W:0]   mant_sum;
`endif
   assign exp_raw = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS;
   always_comb begin
      mant_t      = prod_q[PW-3:MAN_W];
      exp_n       = exp_raw;
`ifdef FP_MUL_ROUND_EN
      guard       = prod_q[MAN_W-1];
      sticky      = |prod_q[MAN_W-2:0];
`endif
      if (prod_q[PW-1]) begin
         mant_t = prod_q[PW-2:MAN_W+1];
         exp_n  = exp_raw + E_ONE;
`ifdef FP_MUL_ROUND_EN
         guard  = prod_q[MAN_W];
         sticky = |prod_q[MAN_W-1:0];
`endif
      end
`ifdef FP_MUL_ROUND_EN
      round_up = guard && (sticky || mant_t[0]);
      mant_sum = {1'b0, mant_t} + {{MAN_W{1'b0}}, round_up};
      // a carry out leaves the stored mantissa at zero and bumps the exponent
      mant_f   = mant_sum[MAN_W-1:0];
      exp_f    = exp_n + $signed({{(EW-1){1'b0}}, mant_sum[MAN_W]});
`else
      mant_f   = mant_t;
      exp_f    = exp_n;
`endif
      norm_result = {sign_r, exp_f[EXP_W-1:0], mant_f};
      norm_status = ST_VALID;
      if (exp_f >= EXP_MAX) begin
         norm_result = {sign_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         norm_status = ST_OVERFLOW;
      end else if (exp_f < E_ONE) begin
         norm_result = {sign_r, {(W-1){1'b0}}};
         norm_status = ST_UNDERFLOW;
      end
   end

   // operand capture, multiply steps and result/handshake registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a_q           <= '0;
         b_q           <= '0;
         prod_q        <= '0;
         cnt_q         <= '0;
         bus.out_valid <= 1'b0;
         bus.result    <= '0;
         bus.status    <= '0;
      end else begin
         case (state_q)
            IDLE: if (bus.in_valid) begin
               a_q    <= bus.a;
               b_q    <= bus.b;
               prod_q <= {{(MAN_W+1){1'b0}}, 1'b1, bus.b[MAN_W-1:0]};
               cnt_q  <= '0;
            end
            MUL: begin
               prod_q <= {step_sum, prod_q[MAN_W:1]};
               cnt_q  <= cnt_q + 1'b1;
            end
            NORM: begin
               bus.result    <= norm_result;
               bus.status    <= norm_status;
               bus.out_valid <= 1'b1;
            end
            DONE: begin
               if (!bus.out_valid) begin
                  bus.result    <= spec_result;
                  bus.status    <= spec_status;
                  bus.out_valid <= 1'b1;
               end else if (bus.out_ready) begin
                  bus.out_valid <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: doc/fp_mul_seq.md
FP_MUL_SEQ -- requirements
Module: fp_mul_seq

Interface
REQ-001 Parameter EXP_W, default 8, exponent field width.
REQ-002 Parameter MAN_W, default 23, stored mantissa width; word width W = 1+EXP_W+MAN_W.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset.
REQ-005 in_valid  input  1  operand pair present.
REQ-006 in_ready  output  1  block can accept operands.
REQ-007 a, b  input  W each  IEEE-style operands {sign, exponent, mantissa}.
REQ-008 out_valid  output  1  result present.
REQ-009 out_ready  input  1  consumer accepts result.
REQ-010 result  output  W  product.
REQ-011 status  output  3  0 VALID, 1 OVERFLOW, 2 UNDERFLOW, 3 NAN, 4 POS_INF, 5 NEG_INF, 6 ZERO.

Function
REQ-012 The FSM SHALL have four states: IDLE, MUL, NORM and DONE.
REQ-013 in_ready SHALL be 1 only in IDLE; an operand pair is accepted on an edge where in_valid&in_ready.
REQ-014 On accept, a and b SHALL be registered; classification per operand: exp==0 is zero (denormals flushed to zero); exp all-ones with mant==0 is infinity; exp all-ones with mant!=0 is NaN; else normal with hidden 1.
REQ-015 Any special operand SHALL move IDLE->DONE directly, with out_valid set on the next edge.
REQ-016 Special-case priority: NaN or (inf x zero) -> quiet NaN {0, all-ones, 1 followed by zeros}, status NAN; inf -> signed inf, status POS_INF/NEG_INF; zero -> signed zero, status ZERO.
REQ-017 Normal operands SHALL go IDLE->MUL; MUL performs one shift-add step per cycle over the (MAN_W+1)-bit multiplier for MAN_W+1 cycles, building a 2*MAN_W+2-bit product; MUL->NORM follows the last step.
REQ-018 NORM SHALL set the exponent to ea+eb-BIAS, with BIAS = 2^(EXP_W-1)-1, in signed EXP_W+2-bit arithmetic; if the product MSB is 1, shift right by 1 and add 1 to the exponent; round per REQ-028; NORM->DONE.
REQ-019 out_valid SHALL assert exactly MAN_W+2 edges after the accept edge for normal operands.
REQ-020 After rounding: exponent >= 2^EXP_W-1 -> signed inf, status OVERFLOW; exponent <= 0 -> signed zero, status UNDERFLOW; else status VALID.
REQ-021 result sign SHALL be sign(a) XOR sign(b) in every case except NaN.
REQ-022 DONE SHALL hold result, status and out_valid stable while out_ready==0; out_valid&out_ready moves DONE->IDLE; out_valid falls on that edge.
REQ-023 A new operand pair SHALL NOT be accepted in the same cycle as a result handoff; there is no overlap.

Reset
REQ-024 With rst_n==0 at an edge, the FSM SHALL go to IDLE, and out_valid, result and status SHALL go to 0, regardless of state.
REQ-025 in_ready SHALL read 1 on the first cycle after reset.
REQ-026 A reset during MUL or NORM SHALL discard the operation; no out_valid is produced for it.
REQ-027 in_valid SHALL be ignored on any edge where rst_n==0.

Configuration
REQ-028 With FP_MUL_ROUND_EN defined, NORM SHALL round to nearest-even using the guard bit and sticky (OR of lower bits); a round carry renormalises, adds 1 to the exponent, and can raise OVERFLOW. Without the macro, the mantissa is truncated, with no extra logic and no other behavioural difference.

Verification
REQ-029 a=0x3FC00000, b=0x40000000 -> result 0x40400000, status VALID, out_valid exactly 25 edges after accept.
REQ-030 a=0x3F800001, b=0x3FC00000 -> 0x3FC00002 with FP_MUL_ROUND_EN (tie to even), 0x3FC00001 without it.
REQ-031 a=0x7F000000, b=0x7F000000 -> 0x7F800000, status OVERFLOW; a=0x00800000, b=0x00800000 -> 0x00000000, status UNDERFLOW.
REQ-032 a=0x7F800000, b=0x00000000 -> 0x7FC00000, status NAN; a=0xFF800000, b=0x40000000 -> 0xFF800000, status NEG_INF; both have out_valid 1 edge after accept.
REQ-033 out_ready held 0 for 10 cycles in DONE -> result and status stable and in_ready 0 throughout; out_ready=1 -> IDLE next edge.
REQ-034 rst_n low for one edge at MUL cycle 10 -> IDLE and in_ready=1 afterwards, with no out_valid for the aborted operation.
